// File: rtl/cla_pipe_adder_if.sv
// Valid/ready operand and result bundle for cla_pipe_adder.
// With APPROX_EN defined the bundle also carries the per-transaction i_approx flag.
interface cla_pipe_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_add1;
   logic [WIDTH-1:0] i_add2;
   logic             i_carry;
`ifdef APPROX_EN
   logic             i_approx;
`endif
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;
   logic             o_carry;

   modport slave (
`ifdef APPROX_EN
      input  i_approx,
`endif
      input  i_valid, i_add1, i_add2, i_carry, i_ready,
      output o_ready, o_valid, o_result, o_carry
   );

   modport master (
`ifdef APPROX_EN
      output i_approx,
`endif
      output i_valid, i_add1, i_add2, i_carry, i_ready,
      input  o_ready, o_valid, o_result, o_carry
   );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: one BLK-bit CLA slice per stage, elastic valid/ready flow.
// Define APPROX_EN to add i_approx (lower-part-OR approximation of the low APPROX_BITS bits).
module cla_pipe_adder #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned BLK         = 4,
   parameter int unsigned APPROX_BITS = 4
) (
   input logic             i_clk,
   input logic             i_rst_n,
   cla_pipe_adder_if.slave bus
);

   localparam int unsigned STAGES = WIDTH / BLK;

   if (BLK == 0 || (WIDTH % BLK) != 0) begin : g_bad_blk
      $error("cla_pipe_adder: WIDTH must be a non-zero multiple of BLK");
   end
   if (APPROX_BITS > WIDTH) begin : g_bad_approx
      $error("cla_pipe_adder: APPROX_BITS must not exceed WIDTH");
   end

   logic             adv;
   logic             run_q, run_d;
   logic             last_vld;
   logic             last_cy;
   logic [WIDTH-1:0] last_sum;

   // Whole pipe shifts together whenever the output slot is free or being consumed.
   assign adv         = ~last_vld | bus.i_ready;
   assign run_d       = 1'b1;
   assign bus.o_ready = adv & run_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) run_q <= 1'b0;
      else          run_q <= run_d;
   end

   for (genvar s = 0; s < int'(STAGES); s++) begin : g_st
      localparam int unsigned LO   = s * BLK;
      localparam int unsigned OPW  = WIDTH - LO;
      localparam int unsigned SW   = LO + BLK;
      localparam bit          LAST = (s == int'(STAGES) - 1);

      logic           vld_in;
      logic           c_in;
      logic [OPW-1:0] a_in;
      logic [OPW-1:0] b_in;
      logic [BLK-1:0] slice;
      logic           c_out;
      logic [SW-1:0]  sum_new;
      logic           vld_q, vld_d;
      logic           cy_q, cy_d;
      logic [SW-1:0]  sum_q, sum_d;
`ifdef APPROX_EN
      logic           apx_in;
`endif

      if (s == 0) begin : g_src
         assign vld_in  = bus.i_valid & bus.o_ready;
         assign a_in    = bus.i_add1;
         assign b_in    = bus.i_add2;
         assign c_in    = bus.i_carry;
         assign sum_new = slice;
`ifdef APPROX_EN
         assign apx_in  = bus.i_approx;
`endif
      end else begin : g_src
         assign vld_in  = g_st[s-1].vld_q;
         assign a_in    = g_st[s-1].g_ops.a_q;
         assign b_in    = g_st[s-1].g_ops.b_q;
         assign c_in    = g_st[s-1].cy_q;
         assign sum_new = {slice, g_st[s-1].sum_q};
`ifdef APPROX_EN
         assign apx_in  = g_st[s-1].g_ops.apx_q;
`endif
      end

      // Ripple-lookahead carries across the slice: c[i+1] = G[i] | P[i]&c[i].
      always_comb begin : p_slice
         logic carry;
         logic g;
         logic p;
         carry = c_in;
         slice = '0;
         g     = 1'b0;
         p     = 1'b0;
         for (int i = 0; i < int'(BLK); i++) begin
            g        = a_in[i] & b_in[i];
            p        = a_in[i] | b_in[i];
            slice[i] = a_in[i] ^ b_in[i] ^ carry;
            carry    = g | (p & carry);
`ifdef APPROX_EN
            // Approximate low part: OR sum, carry chain cut except out of the top approx bit.
            if (apx_in && (int'(LO) + i < int'(APPROX_BITS))) begin
               slice[i] = p;
               carry    = (int'(LO) + i == int'(APPROX_BITS) - 1) ? g : 1'b0;
            end
`endif
         end
         c_out = carry;
      end

      // Bubbles advance only the valid bit so the last stage keeps its last real result.
      always_comb begin : p_next
         vld_d = vld_q;
         cy_d  = cy_q;
         sum_d = sum_q;
         if (adv) begin
            vld_d = vld_in;
            if (vld_in) begin
               cy_d  = c_out;
               sum_d = sum_new;
            end
         end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            sum_q <= '0;
         end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            sum_q <= sum_d;
         end
      end

      if (!LAST) begin : g_ops
         logic [OPW-BLK-1:0] a_q, a_d;
         logic [OPW-BLK-1:0] b_q, b_d;
`ifdef APPROX_EN
         logic               apx_q, apx_d;
`endif

         // Skew: unconsumed operand slices ride along with their transaction.
         always_comb begin : p_ops_next
            a_d = a_q;
            b_d = b_q;
`ifdef APPROX_EN
            apx_d = apx_q;
`endif
            if (adv && vld_in) begin
               a_d = a_in[OPW-1:BLK];
               b_d = b_in[OPW-1:BLK];
`ifdef APPROX_EN
               apx_d = apx_in;
`endif
            end
         end

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               a_q <= '0;
               b_q <= '0;
`ifdef APPROX_EN
               apx_q <= 1'b0;
`endif
            end else begin
               a_q <= a_d;
               b_q <= b_d;
`ifdef APPROX_EN
               apx_q <= apx_d;
`endif
            end
         end
      end
   end

   assign last_vld     = g_st[STAGES-1].vld_q;
   assign last_cy      = g_st[STAGES-1].cy_q;
   assign last_sum     = g_st[STAGES-1].sum_q;
   assign bus.o_valid  = last_vld;
   assign bus.o_result = last_sum;
   assign bus.o_carry  = last_cy;

endmodule
